ibex_cheri_cap_mem_seq: RTL

// - Downstream of the execute block: takes a capability load/store (address from EX adder, 64-bit capability image + tag).
// - Splits each request into two sequential 32-bit data-bus transactions: low word at addr, high word at addr+4.
// - Returns the reassembled 64-bit image + tag, or an error/misaligned indication, to the writeback path.

---
 rtl/ibex_cheri_cap_mem_seq_pkg.sv | 35 +++
 rtl/ibex_cheri_cap_mem_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_cheri_cap_mem_seq_pkg.sv
// Shared types and constants for the capability memory sequencer.
//
// Contents:
//   cap_mem_state_e     - sequencer FSM state (7 states, 3-bit encoding)
//   CAP_MEM_BYTES       - size of one capability image in memory
//   CAP_HI_OFFSET       - byte offset of the high word of a capability
//   cap_addr_misaligned - true when an address is not capability-aligned
//   cap_word_addr       - clears the byte-in-word bits of an address
package ibex_cheri_cap_mem_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMisal  = 3'd1,
    StReqLo  = 3'd2,
    StWaitLo = 3'd3,
    StReqHi  = 3'd4,
    StWaitHi = 3'd5,
    StDone   = 3'd6
  } cap_mem_state_e;

  localparam int unsigned CAP_MEM_BYTES = 8;
  localparam logic [31:0] CAP_HI_OFFSET = 32'd4;

  // A capability must sit on a CAP_MEM_BYTES boundary.
  function automatic logic cap_addr_misaligned(logic [31:0] addr);
    logic [31:0] mask;
    mask = 32'(CAP_MEM_BYTES - 1);
    return |(addr & mask);
  endfunction

  function automatic logic [31:0] cap_word_addr(logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_cheri_cap_mem_seq.sv
// Capability load/store sequencer.
//
// Takes one 64-bit capability access (image + tag) from the execute stage and
// performs it as two back-to-back 32-bit data-bus transactions: the low word at
// the request address, then the high word at address + 4. The reassembled image
// and tag, or an error / misalignment indication, is returned to writeback as a
// single-cycle completion pulse.
//
// Parameters:
//   TagBusEn   - 1: drive data_tag_o and sample data_rtag_i; 0: tags forced to 0
//   AbortOnErr - 1: a bus error on the low beat skips the high beat
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cap_req_i/ready_o     request handshake from EX (accept = req & ready)
//   cap_we_i, cap_addr_i  store/load select and byte address
//   cap_wdata_i/wtag_i    capability image and tag to store
//   cap_valid_o           one-cycle completion pulse
//   cap_rdata_o/rtag_o    loaded image and tag (0 for stores and errors)
//   cap_err_o             bus error seen on any issued beat
//   cap_misaligned_o      address not 8-byte aligned; no bus access performed
//   data_*                32-bit data bus (req/gnt, rvalid response, tag side band)
module ibex_cheri_cap_mem_seq
  import ibex_cheri_cap_mem_seq_pkg::*;
#(
  parameter bit TagBusEn   = 1'b1,
  parameter bit AbortOnErr = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        cap_req_i,
  output logic        cap_ready_o,
  input  logic        cap_we_i,
  input  logic [31:0] cap_addr_i,
  input  logic [63:0] cap_wdata_i,
  input  logic        cap_wtag_i,
  output logic        cap_valid_o,
  output logic [63:0] cap_rdata_o,
  output logic        cap_rtag_o,
  output logic        cap_err_o,
  output logic        cap_misaligned_o,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic        data_tag_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rtag_i,
  input  logic        data_err_i
);

  cap_mem_state_e state_q;

  // Request captured at accept; held for the whole sequence.
  logic        we_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic        wtag_q;

  // Response accumulated across both beats.
  logic [63:0] rdata_q;
  logic        rtag_q;
  logic        err_q;

  logic        rtag_in;
  logic [31:0] hi_addr;

  assign rtag_in = TagBusEn & data_rtag_i;
  assign hi_addr = addr_q + CAP_HI_OFFSET;  // wraps at 2^32

  // Single FSM: state and capture registers advance together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wtag_q  <= 1'b0;
      rdata_q <= '0;
      rtag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cap_req_i) begin
            we_q    <= cap_we_i;
            addr_q  <= cap_addr_i;
            wdata_q <= cap_wdata_i;
            wtag_q  <= TagBusEn & cap_wtag_i;
            rdata_q <= '0;
            rtag_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= cap_addr_misaligned(cap_addr_i) ? StMisal : StReqLo;
          end
        end
        StMisal: state_q <= StIdle;
        StReqLo: begin
          if (data_gnt_i) state_q <= StWaitLo;
        end
        StWaitLo: begin
          if (data_rvalid_i) begin
            rdata_q[31:0] <= data_rdata_i;
            rtag_q        <= rtag_in;
            err_q         <= data_err_i;
            state_q       <= (data_err_i && AbortOnErr) ? StDone : StReqHi;
          end
        end
        StReqHi: begin
          if (data_gnt_i) state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (data_rvalid_i) begin
            rdata_q[63:32] <= data_rdata_i;
            // A capability is only valid if both halves carried a set tag.
            rtag_q         <= rtag_q & rtag_in;
            err_q          <= err_q | data_err_i;
            state_q        <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend on registers only, so they are glitch-free and a reset
  // takes effect on the bus in the same cycle it is asserted.
  always_comb begin
    cap_ready_o      = 1'b0;
    cap_valid_o      = 1'b0;
    cap_rdata_o      = '0;
    cap_rtag_o       = 1'b0;
    cap_err_o        = 1'b0;
    cap_misaligned_o = 1'b0;
    data_req_o       = 1'b0;
    data_we_o        = 1'b0;
    data_be_o        = 4'hF;
    data_addr_o      = '0;
    data_wdata_o     = '0;
    data_tag_o       = 1'b0;

    unique case (state_q)
      StIdle: cap_ready_o = 1'b1;
      StMisal: begin
        cap_valid_o      = 1'b1;
        cap_misaligned_o = 1'b1;
      end
      StReqLo: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_addr_o  = cap_word_addr(addr_q);
        data_wdata_o = we_q ? wdata_q[31:0] : 32'h0;
        data_tag_o   = we_q & wtag_q;
      end
      StReqHi: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_addr_o  = cap_word_addr(hi_addr);
        data_wdata_o = we_q ? wdata_q[63:32] : 32'h0;
        data_tag_o   = we_q & wtag_q;
      end
      StDone: begin
        cap_valid_o = 1'b1;
        cap_err_o   = err_q;
        // Stores and failed loads never expose partially loaded data.
        if (!we_q && !err_q) begin
          cap_rdata_o = rdata_q;
          cap_rtag_o  = rtag_q;
        end
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding indicates a broken bus slave.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(data_rvalid_i && !(state_q inside {StWaitLo, StWaitHi})))
        else $error("data_rvalid_i with no outstanding transaction");
    end
  end
`endif

endmodule
